// File: rtl/player_state_ctrl.sv
// -----------------------------------------------------------------------------
// player_state_ctrl
//
// Player-side controller: shot-slot scheduling with cooldown, life/damage FSM
// with hurt (invulnerable) frames, and independent per-type power-up timers.
// All state advances on the startOfFrame tick. Hit and pickup events that
// arrive between ticks are latched and consumed by the next tick.
//
// Ports
//   clk            in   system clock
//   resetN         in   asynchronous active-low reset
//   startOfFrame   in   one-cycle frame tick
//   shoot          in   fire request level, sampled at tick
//   shot_free      in   per-slot idle flags (1 = may be deployed)
//   hit_pulse      in   player collision event, any cycle
//   out_of_time    in   level timer expiry, sampled at tick
//   pickup_hit     in   pickup collected event, any cycle
//   pickup_type    in   power-up type index, captured with pickup_hit
//   god_mode       in   cheat: permanent invincibility
//   rapid_fire     in   cheat: rapid cooldown
//   deploy_shot    out  one-hot, one-cycle deploy pulse
//   lives          out  remaining lives
//   player_active  out  0 once dead
//   player_red     out  1 while hurt
//   shield         out  god_mode | pu_active[0]
//   more_damage    out  pu_active[2]
//   pu_active      out  per-type power-up active flags (bit 3 always 0)
//   game_over      out  one-cycle pulse on entry to the dead state
// -----------------------------------------------------------------------------
module player_state_ctrl #(
    parameter int unsigned MAX_SHOTS   = 8,
    parameter int unsigned NUM_PU      = 4,
    parameter int unsigned PU_FRAMES   = 1000,
    parameter int unsigned MAX_LIVES   = 3,
    parameter int unsigned START_LIVES = 3,
    parameter int unsigned CD_NORMAL   = 50,
    parameter int unsigned CD_RAPID    = 20,
    parameter int unsigned HURT_FRAMES = 64
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           startOfFrame,
    input  logic                           shoot,
    input  logic [MAX_SHOTS-1:0]           shot_free,
    input  logic                           hit_pulse,
    input  logic                           out_of_time,
    input  logic                           pickup_hit,
    input  logic [$clog2(NUM_PU)-1:0]      pickup_type,
    input  logic                           god_mode,
    input  logic                           rapid_fire,
    output logic [MAX_SHOTS-1:0]           deploy_shot,
    output logic [$clog2(MAX_LIVES+1)-1:0] lives,
    output logic                           player_active,
    output logic                           player_red,
    output logic                           shield,
    output logic                           more_damage,
    output logic [NUM_PU-1:0]              pu_active,
    output logic                           game_over
);

    localparam int unsigned LW     = $clog2(MAX_LIVES + 1);
    localparam int unsigned TypeW  = $clog2(NUM_PU);
    localparam int unsigned PtrW   = (MAX_SHOTS > 1) ? $clog2(MAX_SHOTS) : 1;
    localparam int unsigned CdMax  = (CD_NORMAL > CD_RAPID) ? CD_NORMAL : CD_RAPID;
    localparam int unsigned CdW    = $clog2(CdMax + 1);
    localparam int unsigned HurtW  = $clog2(HURT_FRAMES + 1);
    localparam int unsigned PuW    = $clog2(PU_FRAMES + 1);
    // Type 3 is the extra-life pickup: it has no timer.
    localparam int unsigned PuLife = 3;

    localparam logic [1:0] StAlive = 2'd0;
    localparam logic [1:0] StHurt  = 2'd1;
    localparam logic [1:0] StDead  = 2'd2;

    // State registers
    logic [1:0]           state_q,       state_d;
    logic [LW-1:0]        lives_q,       lives_d;
    logic [HurtW-1:0]     hurt_q,        hurt_d;
    logic [CdW-1:0]       cd_q,          cd_d;
    logic [PtrW-1:0]      ptr_q,         ptr_d;
    logic [PuW-1:0]       pu_cnt_q [NUM_PU];
    logic [PuW-1:0]       pu_cnt_d [NUM_PU];
    logic                 hit_pend_q,    hit_pend_d;
    logic                 pu_pend_q,     pu_pend_d;
    logic [TypeW-1:0]     type_pend_q,   type_pend_d;
    logic [MAX_SHOTS-1:0] deploy_q,      deploy_d;
    logic                 game_over_q,   game_over_d;

    // Combinational helpers
    logic             hit_now;
    logic             pu_now;
    logic [TypeW-1:0] pu_type_now;
    logic             invincible;
    logic             rapid;
    logic [CdW-1:0]   cd_dec;
    logic             dying;
    logic [LW-1:0]    lives_work;
    logic             free_found;
    logic [PtrW-1:0]  free_idx;

    // First free shot slot, scanning upward from ptr_q with wrap-around.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < MAX_SHOTS; i++) begin
            if (!free_found && shot_free[PtrW'((32'(ptr_q) + i) % MAX_SHOTS)]) begin
                free_found = 1'b1;
                free_idx   = PtrW'((32'(ptr_q) + i) % MAX_SHOTS);
            end
        end
    end

    // Events landing in the tick cycle are folded straight into that tick.
    assign hit_now     = hit_pend_q | hit_pulse;
    assign pu_now      = pu_pend_q | pickup_hit;
    assign pu_type_now = pickup_hit ? pickup_type : type_pend_q;

    // Both use the registered power-up state, i.e. the state before this tick.
    assign invincible = (state_q == StHurt) | god_mode | pu_active[0];
    assign rapid      = rapid_fire | pu_active[1];

    assign cd_dec = (cd_q != '0) ? cd_q - 1'b1 : '0;

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        hurt_d      = hurt_q;
        cd_d        = cd_q;
        ptr_d       = ptr_q;
        hit_pend_d  = hit_pend_q;
        pu_pend_d   = pu_pend_q;
        type_pend_d = type_pend_q;
        deploy_d    = '0;
        game_over_d = 1'b0;
        dying       = 1'b0;
        lives_work  = lives_q;
        for (int unsigned i = 0; i < NUM_PU; i++) begin
            pu_cnt_d[i] = pu_cnt_q[i];
        end

        if (!startOfFrame) begin
            if (hit_pulse) begin
                hit_pend_d = 1'b1;
            end
            if (pickup_hit) begin
                pu_pend_d   = 1'b1;
                type_pend_d = pickup_type;
            end
        end else begin
            hit_pend_d = 1'b0;
            pu_pend_d  = 1'b0;

            // Cooldown counts down first, so a shot is ready on the tick the
            // cooldown expires: slot spacing equals the loaded cooldown.
            cd_d = cd_dec;
            if (shoot && (cd_dec == '0) && (state_q != StDead) && free_found) begin
                deploy_d[free_idx] = 1'b1;
                ptr_d = (free_idx == PtrW'(MAX_SHOTS - 1)) ? '0 : free_idx + 1'b1;
                cd_d  = rapid ? CdW'(CD_RAPID) : CdW'(CD_NORMAL);
            end

            if (state_q != StDead) begin
                if (state_q == StHurt) begin
                    hurt_d = (hurt_q != '0) ? hurt_q - 1'b1 : '0;
                    if (hurt_q <= HurtW'(1)) begin
                        state_d = StAlive;
                    end
                end

                if (out_of_time) begin
                    dying = 1'b1;
                end else if (hit_now && !invincible) begin
                    if (lives_q > LW'(1)) begin
                        lives_work = lives_q - 1'b1;
                        state_d    = StHurt;
                        hurt_d     = HurtW'(HURT_FRAMES);
                    end else begin
                        lives_work = '0;
                        dying      = 1'b1;
                    end
                end

                if (dying) begin
                    state_d     = StDead;
                    hurt_d      = '0;
                    game_over_d = 1'b1;
                    for (int unsigned i = 0; i < NUM_PU; i++) begin
                        pu_cnt_d[i] = '0;
                    end
                end else begin
                    for (int unsigned i = 0; i < NUM_PU; i++) begin
                        if (i != PuLife) begin
                            if (pu_cnt_q[i] != '0) begin
                                pu_cnt_d[i] = pu_cnt_q[i] - 1'b1;
                            end
                            if (pu_now && (pu_type_now == TypeW'(i))) begin
                                pu_cnt_d[i] = PuW'(PU_FRAMES);
                            end
                        end
                    end
                    // Extra life is applied after the hit of the same tick.
                    if (pu_now && (pu_type_now == TypeW'(PuLife)) &&
                        (lives_work < LW'(MAX_LIVES))) begin
                        lives_work = lives_work + 1'b1;
                    end
                end
                lives_d = lives_work;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= StAlive;
            lives_q     <= LW'(START_LIVES);
            hurt_q      <= '0;
            cd_q        <= '0;
            ptr_q       <= '0;
            hit_pend_q  <= 1'b0;
            pu_pend_q   <= 1'b0;
            type_pend_q <= '0;
            deploy_q    <= '0;
            game_over_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_PU; i++) begin
                pu_cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            hurt_q      <= hurt_d;
            cd_q        <= cd_d;
            ptr_q       <= ptr_d;
            hit_pend_q  <= hit_pend_d;
            pu_pend_q   <= pu_pend_d;
            type_pend_q <= type_pend_d;
            deploy_q    <= deploy_d;
            game_over_q <= game_over_d;
            for (int unsigned i = 0; i < NUM_PU; i++) begin
                pu_cnt_q[i] <= pu_cnt_d[i];
            end
        end
    end

    always_comb begin
        pu_active = '0;
        for (int unsigned i = 0; i < NUM_PU; i++) begin
            pu_active[i] = (pu_cnt_q[i] != '0);
        end
    end

    assign deploy_shot   = deploy_q;
    assign lives         = lives_q;
    assign player_active = (state_q != StDead);
    assign player_red    = (state_q == StHurt);
    assign shield        = god_mode | pu_active[0];
    assign more_damage   = pu_active[2];
    assign game_over     = game_over_q;

endmodule

// File: tb/tb_player_state_ctrl.sv
// Bench for player_state_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a frame-level behavioural model.
module tb_player_state_ctrl;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       shoot = 1'b0;
    logic [7:0] shot_free = 8'hFF;
    logic       hit_pulse = 1'b0;
    logic       out_of_time = 1'b0;
    logic       pickup_hit = 1'b0;
    logic [1:0] pickup_type = 2'd0;
    logic       god_mode = 1'b0;
    logic       rapid_fire = 1'b0;
    logic [7:0] deploy_shot;
    logic [1:0] lives;
    logic       player_active;
    logic       player_red;
    logic       shield;
    logic       more_damage;
    logic [3:0] pu_active;
    logic       game_over;

    player_state_ctrl dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .shoot        (shoot),
        .shot_free    (shot_free),
        .hit_pulse    (hit_pulse),
        .out_of_time  (out_of_time),
        .pickup_hit   (pickup_hit),
        .pickup_type  (pickup_type),
        .god_mode     (god_mode),
        .rapid_fire   (rapid_fire),
        .deploy_shot  (deploy_shot),
        .lives        (lives),
        .player_active(player_active),
        .player_red   (player_red),
        .shield       (shield),
        .more_damage  (more_damage),
        .pu_active    (pu_active),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: whole-frame arithmetic on integers.
    int         m_lives;
    bit         m_dead;
    int         m_hurt;      // hurt frames left; >0 means red/invulnerable
    int         m_cd;
    int         m_ptr;
    int         m_pu [4];    // frames left per power-up type
    bit         m_ph, m_pp;
    int         m_pt;
    logic [7:0] e_deploy;
    bit         e_go;
    int         tick_no;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h (tick %0d)", tag, obs, exp, tick_no);
    endtask

    task automatic model_reset();
        m_lives = 3; m_dead = 0; m_hurt = 0; m_cd = 0; m_ptr = 0;
        foreach (m_pu[i]) m_pu[i] = 0;
        m_ph = 0; m_pp = 0; m_pt = 0;
        e_deploy = '0; e_go = 0; tick_no = 0;
    endtask

    task automatic model(input bit tick, input bit hit, input bit pu, input int pt);
        bit h, p, inv, rapid, dying;
        int t, slot;
        e_deploy = '0;
        e_go     = 0;
        if (!tick) begin
            if (hit) m_ph = 1;
            if (pu) begin m_pp = 1; m_pt = pt; end
            return;
        end
        tick_no++;
        h = m_ph | hit;
        p = m_pp | pu;
        t = pu ? pt : m_pt;
        m_ph = 0; m_pp = 0;
        inv   = (m_hurt > 0) || god_mode || (m_pu[0] > 0);
        rapid = rapid_fire || (m_pu[1] > 0);
        if (m_cd > 0) m_cd--;
        if (shoot && m_cd == 0 && !m_dead && shot_free != 8'h00) begin
            slot = m_ptr;
            while (!shot_free[slot]) slot = (slot + 1) % 8;
            e_deploy[slot] = 1'b1;
            m_ptr = (slot + 1) % 8;
            m_cd  = rapid ? 20 : 50;
        end
        if (m_dead) return;
        if (m_hurt > 0) m_hurt--;
        dying = 0;
        if (out_of_time) dying = 1;
        else if (h && !inv) begin
            if (m_lives > 1) begin m_lives--; m_hurt = 64; end
            else begin m_lives = 0; dying = 1; end
        end
        if (dying) begin
            m_dead = 1; m_hurt = 0; e_go = 1;
            foreach (m_pu[i]) m_pu[i] = 0;
        end else begin
            foreach (m_pu[i]) if (m_pu[i] > 0) m_pu[i]--;
            if (p) begin
                if (t == 3) begin
                    if (m_lives < 3) m_lives++;
                end else m_pu[t] = 1000;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] e_pu;
        foreach (m_pu[i]) e_pu[i] = (m_pu[i] > 0);
        chk("deploy_shot", deploy_shot, e_deploy);
        chk("lives", lives, m_lives);
        chk("player_active", player_active, !m_dead);
        chk("player_red", player_red, m_hurt > 0);
        chk("pu_active", pu_active, e_pu);
        chk("shield", shield, god_mode | e_pu[0]);
        chk("more_damage", more_damage, e_pu[2]);
        chk("game_over", game_over, e_go);
    endtask

    // One clock cycle: drive at negedge, check 1 time unit after the posedge.
    task automatic step(input bit tick, input bit hit, input bit pu, input int pt);
        @(negedge clk);
        startOfFrame = tick;
        hit_pulse    = hit;
        pickup_hit   = pu;
        pickup_type  = 2'(pt);
        model(tick, hit, pu, pt);
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        hit_pulse    = 1'b0;
        pickup_hit   = 1'b0;
        check_all();
    endtask

    // Idle cycle followed by a tick carrying the given events.
    task automatic frame(input bit hit, input bit pu, input int pt);
        step(0, 0, 0, 0);
        step(1, hit, pu, pt);
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) frame(0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        startOfFrame = 0; hit_pulse = 0; pickup_hit = 0; pickup_type = 0;
        out_of_time = 0; god_mode = 0; rapid_fire = 0; shoot = 0; shot_free = 8'hFF;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        int n_dep, red_cnt;

        // 1: continuous fire with all slots free
        do_reset();
        shoot = 1; shot_free = 8'hFF;
        n_dep = 0;
        for (int k = 1; k <= 120; k++) begin
            frame(0, 0, 0);
            if (deploy_shot != 8'h00) n_dep++;
            if (k == 1)   chk("s1_tick1", deploy_shot, 8'h01);
            if (k == 51)  chk("s1_tick51", deploy_shot, 8'h02);
            if (k == 101) chk("s1_tick101", deploy_shot, 8'h04);
        end
        chk("s1_count", n_dep, 3);
        chk("s1_lives", lives, 3);

        // 2: slot scan from the pointer, then no free slots
        do_reset();
        shoot = 1; shot_free = 8'b0000_0100;
        frame(0, 0, 0);
        chk("s2_first", deploy_shot, 8'h04);
        shot_free = 8'h00;
        run_frames(60);
        shot_free = 8'b0000_1001;
        frame(0, 0, 0);
        chk("s2_ptr_wrap", deploy_shot, 8'h08);

        // 3: hurt frames and ignored hit while hurt
        do_reset();
        run_frames(4);
        frame(1, 0, 0);
        chk("s3_hit5_lives", lives, 2);
        red_cnt = player_red ? 1 : 0;
        for (int k = 6; k <= 79; k++) begin
            frame(k == 30, 0, 0);
            if (player_red) red_cnt++;
            if (k == 30) chk("s3_hit30_ignored", lives, 2);
        end
        chk("s3_red_frames", red_cnt, 64);
        frame(1, 0, 0);
        chk("s3_hit80_lives", lives, 1);

        // 4: fatal hit latched between ticks
        run_frames(70);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        chk("s4_lives", lives, 0);
        chk("s4_active", player_active, 0);
        chk("s4_game_over", game_over, 1);
        step(0, 0, 0, 0);
        chk("s4_game_over_pulse", game_over, 0);
        shoot = 1;
        run_frames(5);
        chk("s4_no_shot", deploy_shot, 8'h00);

        // 5: rapid-fire power-up and re-pickup
        do_reset();
        shoot = 1;
        frame(0, 1, 1);
        for (int k = 2; k <= 1510; k++) begin
            frame(0, k == 500, 1);
            if (k == 51)   chk("s5_shot51", deploy_shot, 8'h02);
            if (k == 71)   chk("s5_rapid71", deploy_shot, 8'h04);
            if (k == 1499) chk("s5_active1499", pu_active[1], 1);
            if (k == 1500) chk("s5_off1500", pu_active[1], 0);
        end

        // 6: hit plus extra life in the same frame
        do_reset();
        frame(1, 0, 0);
        run_frames(65);
        step(0, 1, 1, 3);
        step(1, 0, 0, 0);
        chk("s6_lives2_kept", lives, 2);
        run_frames(65);
        frame(1, 0, 0);
        run_frames(65);
        chk("s6_lives1", lives, 1);
        step(0, 1, 1, 3);
        step(1, 0, 0, 0);
        chk("s6_fatal", lives, 0);
        chk("s6_fatal_go", game_over, 1);
        do_reset();
        frame(0, 1, 3);
        chk("s6_life_cap", lives, 3);

        // 7: random traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 399) == 0 || (m_dead && $urandom_range(0, 19) == 0)) begin
                do_reset();
            end else begin
                shoot       = $urandom_range(0, 3) != 0;
                shot_free   = 8'($urandom);
                rapid_fire  = $urandom_range(0, 7) == 0;
                god_mode    = $urandom_range(0, 15) == 0;
                out_of_time = $urandom_range(0, 299) == 0;
                step($urandom_range(0, 1), $urandom_range(0, 15) == 0,
                     $urandom_range(0, 15) == 0, int'($urandom_range(0, 3)));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
